addsub_accumulator: RTL
=======================

ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begins a new accumulation when the FSM is in IDLE.
REQ-005 in_valid  input  1  operand beat is present.
REQ-006 in_data  input  5  two's-complement operand.
REQ-007 in_op  input  1  0 = add, 1 = subtract (acc - in_data).
REQ-008 in_last  input  1  marks the final beat of a sequence.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 x  output  5  adder operand A; x = acc.
REQ-011 y  output  5  adder operand B; y = in_data.
REQ-012 opcode  output  1  adder mode, also its carry-in; opcode = in_op.
REQ-013 sum  input  5  adder result.
REQ-014 carry_out  input  1  adder carry out.
REQ-015 overflow  input  1  adder signed overflow.
REQ-016 result  output  5  final accumulator value.
REQ-017 result_valid  output  1  one-cycle pulse qualifying result.
REQ-018 carry_flag  output  1  carry_out of the last accepted beat.
REQ-019 ovf_sticky  output  1  OR of overflow over all accepted beats of the sequence.
REQ-020 op_count  output  4  number of accepted beats, saturating.
REQ-021 busy  output  1  high in ACC and DONE.

Function
REQ-022 FSM states SHALL be IDLE, ACC and DONE; reset state IDLE.
REQ-023 IDLE: in_ready=0; start=1 SHALL clear acc, carry_flag, ovf_sticky and op_count to 0 and go to ACC on the next edge.
REQ-024 start SHALL be ignored in ACC and DONE.
REQ-025 ACC: in_ready=1; a beat is accepted on an edge where in_valid=1 and in_ready=1.
REQ-026 On accept: acc<=sum, carry_flag<=carry_out, ovf_sticky<=ovf_sticky|overflow, op_count<=op_count+1 saturating at 15.
REQ-027 An accept with in_last=1 SHALL move the FSM to DONE; otherwise the FSM stays in ACC.
REQ-028 in_valid=0 in ACC SHALL hold all state unchanged, with no timeout.
REQ-029 DONE: result_valid=1 for exactly one cycle, result=acc, in_ready=0; the next state is IDLE.
REQ-030 result SHALL hold its last value until the next DONE.
REQ-031 x, y and opcode SHALL be combinational pass-throughs, driven in every state.
REQ-032 Arithmetic SHALL be 5-bit modulo-32; acc wraps and never saturates; only ovf_sticky records wrap.
REQ-033 Latency: result_valid SHALL be asserted in the cycle after the in_last accept edge.

Reset
REQ-034 Reset SHALL act immediately, without waiting for a clock edge, including mid-sequence.
REQ-035 While reset is high, every register SHALL be 0: acc, result, result_valid, carry_flag, ovf_sticky, op_count, busy.
REQ-036 While reset is high, in_ready SHALL be 0.
REQ-037 After reset is released, the FSM SHALL be in IDLE and the interrupted sequence SHALL be discarded, with no result_valid.

Verification
REQ-038 Add 3, then add 4 with in_last -> result=7, ovf_sticky=0, op_count=2, result_valid pulses one cycle after the last accept.
REQ-039 Add 15, then add 1, then sub 1 with in_last -> intermediate acc=16 (-16) with overflow; result=15, ovf_sticky=1.
REQ-040 Sub 1 from 0 with in_last -> result=31 (-1), carry_flag=0, ovf_sticky=0.
REQ-041 17 add-1 beats, last with in_last -> result=17, op_count=15, ovf_sticky=1 (overflow at 15+1).
REQ-042 Assert reset after 2 beats in ACC -> all outputs 0 at once; then start with add 5 and in_last -> result=5, op_count=1.
REQ-043 Pulse start in ACC, and insert in_valid gaps -> state unaffected and in_ready stays 1; start in DONE -> ignored.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Sequenced add/subtract accumulator. It drives an external 5-bit adder through
// x/y/opcode and stores that adder's sum and flags when it accepts a beat.
module addsub_accumulator (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [4:0] in_data,
   input  logic       in_op,
   input  logic       in_last,
   output logic       in_ready,
   output logic [4:0] x,
   output logic [4:0] y,
   output logic       opcode,
   input  logic [4:0] sum,
   input  logic       carry_out,
   input  logic       overflow,
   output logic [4:0] result,
   output logic       result_valid,
   output logic       carry_flag,
   output logic       ovf_sticky,
   output logic [3:0] op_count,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic       w_clear;
   logic       w_accept;
   logic [4:0] r_acc;
   logic [4:0] r_result;
   logic       r_carry;
   logic       r_ovf;
   logic [3:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so that every register
   // samples values from before the edge, whatever order the blocks run in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: each output of this block gets a default first, so no path through
   // the case statement can leave a variable unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear      = 1'b1;
               w_state_next = S_ACC;
            end
         end
         S_ACC: begin
            if (in_valid) begin
               w_accept = 1'b1;
               if (in_last) w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // The result is loaded on the final accept, so it is visible during DONE.
   // It then holds until the next sequence completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc    <= 5'd0;
         r_result <= 5'd0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_count  <= 4'd0;
      end else if (w_clear) begin
         r_acc   <= 5'd0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= 4'd0;
      end else if (w_accept) begin
         r_acc   <= sum;
         r_carry <= carry_out;
         r_ovf   <= r_ovf | overflow;
         if (r_count != 4'd15) r_count <= r_count + 4'd1;
         if (in_last)          r_result <= sum;
      end
   end

   assign in_ready     = (r_state == S_ACC);
   assign result_valid = (r_state == S_DONE);
   assign busy         = (r_state != S_IDLE);
   assign x            = r_acc;
   assign y            = in_data;
   assign opcode       = in_op;
   assign result       = r_result;
   assign carry_flag   = r_carry;
   assign ovf_sticky   = r_ovf;
   assign op_count     = r_count;

endmodule
